reg_file_p: RTL



---
 rtl/reg_file_p.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reg_file_p.sv
// Parametrised 2-read/2-write register file with same-cycle write-to-read
// bypass, optional hardwired-zero entry 0 and a post-reset clear sequencer.
module reg_file_p #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic              ready
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic              ready_r;
  logic [DATA_W-1:0] regs_r [DEPTH];

  logic              running_s;
  logic              we_a_s;
  logic              we_b_s;
  logic [DATA_W-1:0] rd_data1_s;
  logic [DATA_W-1:0] rd_data2_s;

  // Read priority: not ready, hardwired zero, bypass A, bypass B, storage.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              run,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              en_a,
    input logic [ADDR_W-1:0] addr_a,
    input logic [DATA_W-1:0] data_a,
    input logic              en_b,
    input logic [ADDR_W-1:0] addr_b,
    input logic [DATA_W-1:0] data_b
  );
    logic [DATA_W-1:0] res;
    if (!run) begin
      res = ZERO_DATA;
    end else if (ZERO_REG && (addr == ZERO_ADDR)) begin
      res = ZERO_DATA;
    end else if (BYPASS && en_a && (addr == addr_a)) begin
      res = data_a;
    end else if (BYPASS && en_b && (addr == addr_b)) begin
      res = data_b;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Clear/run sequencer; ready rises on the edge that clears the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_ptr_r <= {ADDR_W{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
          if (clr_ptr_r == LAST_ADDR) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            state_r <= CLEAR;
            ready_r <= 1'b0;
          end
        end
        RUN: begin
          state_r <= RUN;
          ready_r <= 1'b1;
        end
        default: begin
          state_r   <= CLEAR;
          clr_ptr_r <= {ADDR_W{1'b0}};
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Write qualification: dropped while clearing, to a hardwired zero, or when B loses to A.
  always_comb begin
    running_s = (state_r == RUN);
    we_a_s    = running_s && wr_en_a && !(ZERO_REG && (wr_addr_a == ZERO_ADDR));
    we_b_s    = running_s && wr_en_b && !(ZERO_REG && (wr_addr_b == ZERO_ADDR))
                && !(wr_en_a && (wr_addr_b == wr_addr_a));
  end

  // Storage is deliberately not reset; the sequencer sweeps zeros through it instead.
  always_ff @(posedge clk) begin
    if (state_r == CLEAR) begin
      regs_r[clr_ptr_r] <= ZERO_DATA;
    end else begin
      if (we_b_s) begin
        regs_r[wr_addr_b] <= wr_data_b;
      end
      if (we_a_s) begin
        regs_r[wr_addr_a] <= wr_data_a;
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data1_s = read_mux(running_s, rd_addr1, regs_r[rd_addr1], wr_en_a, wr_addr_a,
                          wr_data_a, wr_en_b, wr_addr_b, wr_data_b);
    rd_data2_s = read_mux(running_s, rd_addr2, regs_r[rd_addr2], wr_en_a, wr_addr_a,
                          wr_data_a, wr_en_b, wr_addr_b, wr_data_b);
  end

  assign rd_data1 = rd_data1_s;
  assign rd_data2 = rd_data2_s;
  assign ready    = ready_r;

endmodule
